// File: rtl/jpeg_dec_pkg.sv
// Shared definitions for the JPEG decode page output path: token layout and
// sequencer state encoding.
package jpeg_dec_pkg;

    localparam int unsigned CHAN_W   = 3;
    localparam int unsigned COEF_W   = 9;

    // Tagged token layout: {chan[CHAN_W-1:0], coef[COEF_W-1:0]}
    localparam int unsigned COEF_LSB = 0;
    localparam int unsigned CHAN_LSB = COEF_W;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        COLLECT = 2'd1,
        EMIT    = 2'd2
    } decState_e;

endpackage

// File: rtl/jpeg_dec_out_reg.sv
// Single-entry pipelined output register with valid/back-pressure handshake;
// loads and unloads in the same cycle so a full-rate stream has no bubbles.
module jpeg_dec_out_reg #(
    parameter int unsigned W = 12
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] loadD,
    input  logic         loadE,
    output logic         canLoad,
    output logic [W-1:0] outD,
    output logic         outE,
    output logic         outV,
    input  logic         outB
);

    assign canLoad = !outV || !outB;

    always_ff @(posedge clock) begin
        if (reset) begin
            outV <= 1'b0;
            outE <= 1'b0;
            outD <= '0;
        end else if (canLoad) begin
            outV <= load;
            if (load) begin
                outD <= loadD;
                outE <= loadE;
            end
        end
    end

endmodule

// File: rtl/jpeg_dec_coef_serializer.sv
// Round-robin merge of the eight coefficient channels into one tagged stream,
// with row/block tracking and end-of-stream alignment across channels.
module jpeg_dec_coef_serializer
    import jpeg_dec_pkg::*;
#(
    parameter int unsigned NCH  = 8,
    parameter int unsigned DW   = COEF_W,
    parameter int unsigned ROWS = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NCH*DW-1:0]     in_d,
    input  logic [NCH-1:0]        in_e,
    input  logic [NCH-1:0]        in_v,
    output logic [NCH-1:0]        in_b,
    output logic [DW+CHAN_W-1:0]  out_d,
    output logic                  out_e,
    output logic                  out_v,
    input  logic                  out_b,
    output logic                  blk_done,
    output logic                  err_eos
);

    localparam int unsigned ROW_W = $clog2(ROWS);

    decState_e            state, stateNext;
    logic [CHAN_W-1:0]    ptr, ptrNext;
    logic [ROW_W-1:0]     row, rowNext;
    logic                 canLoad, portOpen, accept;
    logic                 load, loadE, blkPulse, errSet;
    logic [DW+CHAN_W-1:0] loadD;
    logic [DW-1:0]        curD;
    logic                 curE;

    // Only the channel under the pointer is ever offered a slot; in_b never looks at in_v.
    assign portOpen = !reset && canLoad && (state != EMIT);
    assign accept   = portOpen && in_v[ptr];
    assign curD     = in_d[int'(ptr)*DW +: DW];
    assign curE     = in_e[ptr];

    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            in_b[i] = !(portOpen && (CHAN_W'(i) == ptr));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= RUN;
            ptr     <= '0;
            row     <= '0;
            err_eos <= 1'b0;
        end else begin
            state <= stateNext;
            ptr   <= ptrNext;
            row   <= rowNext;
            if (errSet) begin
                err_eos <= 1'b1;
            end
        end
    end

    always_comb begin
        stateNext = state;
        ptrNext   = ptr;
        rowNext   = row;
        load      = 1'b0;
        loadE     = 1'b0;
        loadD     = '0;
        blkPulse  = 1'b0;
        errSet    = 1'b0;
        loadD[CHAN_LSB +: CHAN_W] = ptr;
        loadD[COEF_LSB +: DW]     = curD;

        unique case (state)
            RUN: begin
                if (accept) begin
                    ptrNext = ptr + 1'b1;
                    if (!curE) begin
                        load = 1'b1;
                        if (ptr == CHAN_W'(NCH - 1)) begin
                            if (row == ROW_W'(ROWS - 1)) begin
                                rowNext  = '0;
                                blkPulse = 1'b1;
                            end else begin
                                rowNext = row + 1'b1;
                            end
                        end
                    end else if (ptr == '0) begin
                        stateNext = COLLECT;
                        errSet    = (row != '0);
                    end else begin
                        errSet = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (accept) begin
                    ptrNext = ptr + 1'b1;
                    errSet  = !curE;
                    if (ptr == CHAN_W'(NCH - 1)) begin
                        stateNext = EMIT;
                    end
                end
            end
            EMIT: begin
                if (canLoad) begin
                    load      = 1'b1;
                    loadE     = 1'b1;
                    loadD     = '0;
                    stateNext = RUN;
                    ptrNext   = '0;
                    rowNext   = '0;
                end
            end
            default: stateNext = RUN;
        endcase
    end

    assign blk_done = !reset && blkPulse;

    jpeg_dec_out_reg #(
        .W (DW + CHAN_W)
    ) uOutReg (
        .clock   (clock),
        .reset   (reset),
        .load    (load),
        .loadD   (loadD),
        .loadE   (loadE),
        .canLoad (canLoad),
        .outD    (out_d),
        .outE    (out_e),
        .outV    (out_v),
        .outB    (out_b)
    );

endmodule
